// File: rtl/jtcps_obj_linebuf.sv
// Double-buffered object line buffer: the draw engine fills one bank while video
// reads and clears the other. Priority between overlapping objects is resolved by read-modify-write.
module jtcps_obj_linebuf #(
  parameter int         DW         = 9,
  parameter int         AW         = 9,
  parameter logic [3:0] TRANSP     = 4'hF,
  parameter bit         PRIO_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic          line,
  input  logic [AW-1:0] hdump,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_wr,
  output logic          ready,
  output logic [DW-1:0] pxl
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic { INIT, RUN } state_t;

  state_t        state;
  logic [AW:0]   init_cnt;

  logic [DW-1:0] mem [0:1][0:DEPTH-1];

  logic          s1_valid, s1_bank;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic          s2_valid, s2_bank;
  logic [AW-1:0] s2_addr;
  logic [DW-1:0] s2_data, s2_old;

  logic          rd_pend, rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  logic [AW-1:0] ra;
  logic          s2_commit, fwd;
  logic [1:0]    we;
  logic [AW-1:0] wa [2];
  logic [DW-1:0] wd [2];

  assign ra        = flip ? ~hdump : hdump;
  assign s2_commit = s2_valid && (s2_data[3:0] != TRANSP) &&
                     (!PRIO_FIRST || s2_old[3:0] == TRANSP);
  // A commit landing on the pixel S1 is reading makes the memory read stale.
  assign fwd       = s2_commit && s2_addr == s1_addr && s2_bank == s1_bank;

  // Per-bank write port: init sweep, then clear-after-read, then pixel commit.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we[b] = 1'b0;
      wa[b] = s2_addr;
      wd[b] = s2_data;
      if (state == INIT) begin
        we[b] = !init_cnt[AW];
        wa[b] = init_cnt[AW-1:0];
        wd[b] = '1;
      end else if (rd_pend && rd_bank == b[0]) begin
        we[b] = 1'b1;
        wa[b] = rd_addr;
        wd[b] = '1;
      end else if (s2_commit && s2_bank == b[0]) begin
        we[b] = 1'b1;
      end
    end
  end

  // NOTE: storage and its read registers carry no reset; the init sweep clears
  // the banks, and every consumer of these registers is qualified by a reset valid bit.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (we[b]) mem[b][wa[b]] <= wd[b];
    s2_old  <= fwd ? s2_data : mem[s1_bank][s1_addr];
    rd_data <= mem[line][ra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
      s1_valid <= 1'b0;
      s1_bank  <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_bank  <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
      rd_pend  <= 1'b0;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
      pxl      <= '1;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt[AW]) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase

      s1_valid <= (state == RUN) && buf_wr;
      s1_bank  <= ~line;
      s1_addr  <= buf_addr;
      s1_data  <= buf_data;

      s2_valid <= s1_valid;
      s2_bank  <= s1_bank;
      s2_addr  <= s1_addr;
      s2_data  <= s1_data;

      rd_pend  <= (state == RUN) && pxl_cen;
      rd_bank  <= line;
      rd_addr  <= ra;
      if (rd_pend) pxl <= rd_data;
    end
  end

endmodule

// File: tb/tb_jtcps_obj_linebuf.sv
// Directed bench for jtcps_obj_linebuf: a first-wins AW=9 instance and a
// last-wins AW=4 instance share stimulus; read results are scoreboarded.
module tb_jtcps_obj_linebuf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       flip = 1'b0;
  logic       line = 1'b0;
  logic [8:0] hdump = '0;
  logic [8:0] buf_addr = '0;
  logic [8:0] buf_data = '0;
  logic       buf_wr = 1'b0;
  logic       ready_a, ready_b;
  logic [8:0] pxl_a, pxl_b;

  int tests = 0;
  int fails = 0;

  string      sb_tag [$];
  logic [8:0] sb_a   [$];
  logic [8:0] sb_b   [$];

  always #5 clk = ~clk;

  jtcps_obj_linebuf #(.DW(9), .AW(9), .TRANSP(4'hF), .PRIO_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip), .line(line),
    .hdump(hdump), .buf_addr(buf_addr), .buf_data(buf_data), .buf_wr(buf_wr),
    .ready(ready_a), .pxl(pxl_a)
  );

  jtcps_obj_linebuf #(.DW(9), .AW(4), .TRANSP(4'hF), .PRIO_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip), .line(line),
    .hdump(hdump[3:0]), .buf_addr(buf_addr[3:0]), .buf_data(buf_data), .buf_wr(buf_wr),
    .ready(ready_b), .pxl(pxl_b)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [8:0] d);
    buf_addr = a;
    buf_data = d;
    buf_wr   = 1'b1;
    @(negedge clk);
    buf_wr   = 1'b0;
  endtask

  // Issue a pxl_cen read, queue the expectations, then compare once pxl updates.
  task automatic read_px(input logic [8:0] h, input logic [8:0] ea, input logic [8:0] eb,
                         input string tag);
    string t;
    hdump   = h;
    pxl_cen = 1'b1;
    sb_tag.push_back(tag);
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    @(negedge clk);
    pxl_cen = 1'b0;
    @(negedge clk);
    t = sb_tag.pop_front();
    check({t, "_a"}, pxl_a, sb_a.pop_front());
    check({t, "_b"}, pxl_b, sb_b.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle(2);
    check("rst_pxl_a",   pxl_a,   9'h1FF);
    check("rst_pxl_b",   pxl_b,   9'h1FF);
    check("rst_ready_a", {8'd0, ready_a}, 9'd0);
    check("rst_ready_b", {8'd0, ready_b}, 9'd0);

    // Init timing on the 16-pixel instance: low through 16 sweep clocks.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("init_busy_%0d", k), {8'd0, ready_b}, 9'd0);
    end
    @(negedge clk);
    check("init_ready_b", {8'd0, ready_b}, 9'd1);
    check("init_busy_a",  {8'd0, ready_a}, 9'd0);

    for (int i = 0; i < 600 && !ready_a; i++) @(negedge clk);
    check("init_ready_a", {8'd0, ready_a}, 9'd1);

    // Full sweep of both banks reads transparent.
    for (int bank = 0; bank < 2; bank++) begin
      line = bank[0];
      for (int i = 0; i < 16; i++)
        read_px(9'(i), 9'h1FF, 9'h1FF, $sformatf("init_bank%0d_%0d", bank, i));
    end
    line = 1'b0;
    idle(2);

    // Priority: back-to-back writes to the same pixel.
    wr(9'd5, 9'h012);
    wr(9'd5, 9'h034);
    idle(3);
    line = 1'b1;
    idle(1);
    read_px(9'd5, 9'h012, 9'h034, "prio");

    // Transparency: transparent write discarded, later opaque accepted.
    wr(9'd7, 9'h05F);
    idle(1);
    wr(9'd7, 9'h021);
    idle(3);
    line = 1'b0;
    idle(1);
    read_px(9'd7, 9'h021, 9'h021, "transp");

    // Clear-after-read across two line toggles.
    wr(9'd3, 9'h044);
    idle(3);
    line = 1'b1;
    idle(1);
    read_px(9'd3, 9'h044, 9'h044, "clr_first");
    line = 1'b0;
    idle(2);
    line = 1'b1;
    idle(2);
    read_px(9'd3, 9'h1FF, 9'h1FF, "clr_again");
    read_px(9'd5, 9'h1FF, 9'h1FF, "clr_prio_pixel");

    // Flip: hdump 511 maps to pixel 0.
    wr(9'd0, 9'h066);
    idle(3);
    line = 1'b0;
    idle(1);
    flip = 1'b1;
    read_px(9'd511, 9'h066, 9'h066, "flip_hi");
    read_px(9'd0,   9'h1FF, 9'h1FF, "flip_lo");
    flip = 1'b0;

    // Bank capture: write issued the clk before line toggles.
    buf_addr = 9'd9;
    buf_data = 9'h077;
    buf_wr   = 1'b1;
    @(negedge clk);
    buf_wr   = 1'b0;
    line     = 1'b1;
    idle(3);
    read_px(9'd9, 9'h077, 9'h077, "capture_old_bank");
    line = 1'b0;
    idle(1);
    read_px(9'd9, 9'h1FF, 9'h1FF, "capture_new_bank");

    tests++;
    assert (sb_tag.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb_tag.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
